// File: rtl/dco_tune_ctrl.sv
// rtl/dco_tune_ctrl.sv - DCO capacitor-bank successive-approximation calibration sequencer
// Searches L[4:0], then M[7:0], then S[7:0]; each trial bit is judged by an external frequency measurement.
module dco_tune_ctrl #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       meas_done,
  input  logic       meas_fast,
  output logic       meas_req,
  output logic       pd,
  output logic       en,
  output logic [4:0] c_l_word,
  output logic [7:0] c_m_word,
  output logic [7:0] c_s_word,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_TRIAL, S_SETTLE, S_MEAS, S_DECIDE, S_DONE
  } state_t;

  localparam logic [1:0] BANK_L = 2'd0;
  localparam logic [1:0] BANK_M = 2'd1;
  localparam logic [1:0] BANK_S = 2'd2;
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] bank_q, bank_d;
  logic [2:0] bit_q, bit_d;
  logic       fast_q, fast_d;
  logic       meas_req_d, pd_d, en_d, busy_d, done_d, err_d;
  logic [4:0] l_d;
  logic [7:0] m_d, s_d;

  logic timeout, accept, last_bit;

  // cnt_q is 0 in the meas_req cycle, so a same-cycle meas_done is rejected.
  assign timeout  = (state_q == S_MEAS) && (cnt_q == TIMEOUT_LAST);
  assign accept   = (state_q == S_MEAS) && meas_done && (cnt_q != 8'd0) && !timeout;
  assign last_bit = (bank_q == BANK_S) && (bit_q == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_PWRUP;
      S_PWRUP:  if (cnt_q == SETTLE_LAST) state_d = S_TRIAL;
      S_TRIAL:  state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_MEAS;
      S_MEAS: begin
        if (timeout)     state_d = S_IDLE;
        else if (accept) state_d = S_DECIDE;
      end
      S_DECIDE: state_d = last_bit ? S_DONE : S_TRIAL;
      S_DONE:   if (start) state_d = S_PWRUP;
      default:  state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d      = (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
    bank_d     = bank_q;
    bit_d      = bit_q;
    fast_d     = fast_q;
    meas_req_d = 1'b0;
    pd_d       = pd;
    en_d       = en;
    busy_d     = busy;
    done_d     = done;
    err_d      = err;
    l_d        = c_l_word;
    m_d        = c_m_word;
    s_d        = c_s_word;
    if (state_d == S_IDLE && state_q != S_IDLE) begin
      // abort or timeout: park the DCO with reset words; abort outranks timeout for err
      pd_d   = 1'b1;
      en_d   = 1'b0;
      busy_d = 1'b0;
      l_d    = 5'd16;
      m_d    = 8'd128;
      s_d    = 8'd128;
      err_d  = err | (timeout && !abort);
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_d == S_PWRUP) begin
            l_d    = 5'd0;
            m_d    = 8'd128;
            s_d    = 8'd128;
            err_d  = 1'b0;
            done_d = 1'b0;
            en_d   = 1'b1;
            pd_d   = 1'b0;
            busy_d = 1'b1;
            bank_d = BANK_L;
            bit_d  = 3'd4;
          end
        end
        S_TRIAL: begin
          // the MSB trial of M and S also clears that bank's mid-scale preset
          case (bank_q)
            BANK_L:  l_d = c_l_word | (5'd1 << bit_q);
            BANK_M:  m_d = (bit_q == 3'd7) ? 8'h80 : (c_m_word | (8'd1 << bit_q));
            default: s_d = (bit_q == 3'd7) ? 8'h80 : (c_s_word | (8'd1 << bit_q));
          endcase
        end
        S_SETTLE: meas_req_d = (state_d == S_MEAS);
        S_MEAS:   if (accept) fast_d = meas_fast;
        S_DECIDE: begin
          if (!fast_q) begin
            case (bank_q)
              BANK_L:  l_d = c_l_word & ~(5'd1 << bit_q);
              BANK_M:  m_d = c_m_word & ~(8'd1 << bit_q);
              default: s_d = c_s_word & ~(8'd1 << bit_q);
            endcase
          end
          if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1;
          end else if (bank_q == BANK_L) begin
            bank_d = BANK_M;
            bit_d  = 3'd7;
          end else if (bank_q == BANK_M) begin
            bank_d = BANK_S;
            bit_d  = 3'd7;
          end
          if (state_d == S_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 8'd0;
      bank_q   <= BANK_L;
      bit_q    <= 3'd0;
      fast_q   <= 1'b0;
      meas_req <= 1'b0;
      pd       <= 1'b1;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      c_l_word <= 5'd16;
      c_m_word <= 8'd128;
      c_s_word <= 8'd128;
    end else begin
      cnt_q    <= cnt_d;
      bank_q   <= bank_d;
      bit_q    <= bit_d;
      fast_q   <= fast_d;
      meas_req <= meas_req_d;
      pd       <= pd_d;
      en       <= en_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      c_l_word <= l_d;
      c_m_word <= m_d;
      c_s_word <= s_d;
    end
  end

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// tb/tb_dco_tune_ctrl.sv - directed bench for dco_tune_ctrl
// Measurement model returns meas_done 3 cycles after meas_req; SETTLE_CYC=4, TIMEOUT_CYC=10.
module tb_dco_tune_ctrl;

  logic       clk, rst, start, abort, meas_done, meas_fast;
  logic       meas_req, pd, en, busy, done, err;
  logic [4:0] c_l_word;
  logic [7:0] c_m_word, c_s_word;

  logic resp_done, resp_fast, spur_done;
  logic resp_en;
  int   resp_mode;
  int   checks, failures;
  int   busy_cnt, req_cnt, saved_req;

  assign meas_done = resp_done | spur_done;
  assign meas_fast = resp_fast;

  dco_tune_ctrl #(.SETTLE_CYC(4), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .meas_done(meas_done), .meas_fast(meas_fast), .meas_req(meas_req),
    .pd(pd), .en(en), .c_l_word(c_l_word), .c_m_word(c_m_word),
    .c_s_word(c_s_word), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frequency-measurement model: mode 0 = target compare, 1 = always slow, 2 = always fast
  initial begin
    resp_done = 1'b0;
    resp_fast = 1'b0;
    forever begin
      @(negedge clk);
      if (meas_req && resp_en) begin
        repeat (3) @(posedge clk);
        #1;
        if (resp_mode == 0)      resp_fast = ({c_l_word, c_m_word, c_s_word} < {5'd28, 8'd200, 8'd50});
        else if (resp_mode == 1) resp_fast = 1'b0;
        else                     resp_fast = 1'b1;
        resp_done = 1'b1;
        @(posedge clk);
        #1;
        resp_done = 1'b0;
        resp_fast = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy)     busy_cnt++;
      if (meas_req) req_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic hold);
    @(posedge clk);
    #1;
    start    = 1'b1;
    busy_cnt = 0;
    req_cnt  = 0;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pd"}, pd, 1);
    check({tag, "_en"}, en, 0);
    check({tag, "_l"}, c_l_word, 16);
    check({tag, "_m"}, c_m_word, 128);
    check({tag, "_s"}, c_s_word, 128);
  endtask

  initial begin
    checks = 0; failures = 0; busy_cnt = 0; req_cnt = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; spur_done = 1'b0;
    resp_en = 1'b1; resp_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_parked("rst");
    check("rst_req", meas_req, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Scenario 1: target search
    launch(1'b0);
    @(negedge clk);
    check("s1_busy_c1", busy, 1);
    check("s1_pd_c1", pd, 0);
    check("s1_en_c1", en, 1);
    check("s1_l_c1", c_l_word, 0);
    check("s1_m_c1", c_m_word, 128);
    repeat (9) @(negedge clk);
    check("s1_req_c10", meas_req, 1);
    check("s1_l_c10", c_l_word, 16);
    wait_done("s1_done", 400);
    check("s1_l", c_l_word, 28);
    check("s1_m", c_m_word, 199);
    check("s1_s", c_s_word, 255);
    check("s1_busy_cycles", busy_cnt, 214);
    check("s1_req_pulses", req_cnt, 21);
    check("s1_busy_end", busy, 0);
    check("s1_err", err, 0);

    // Scenario 2: always slow
    resp_mode = 1;
    launch(1'b0);
    @(negedge clk);
    wait_done("s2_done", 400);
    check("s2_l", c_l_word, 0);
    check("s2_m", c_m_word, 0);
    check("s2_s", c_s_word, 0);

    // Scenario 3: always fast
    resp_mode = 2;
    launch(1'b0);
    @(negedge clk);
    wait_done("s3_done", 400);
    check("s3_l", c_l_word, 31);
    check("s3_m", c_m_word, 255);
    check("s3_s", c_s_word, 255);

    // Scenario 4: abort during the M search (cycle 70 = MEAS of M bit 6)
    resp_mode = 0;
    launch(1'b0);
    repeat (70) @(negedge clk);
    check("ab_l_pre", c_l_word, 28);
    check("ab_m_pre", c_m_word, 192);
    check("ab_s_pre", c_s_word, 128);
    pulse_abort();
    check_parked("ab");
    check("ab_done", done, 0);
    saved_req = req_cnt;
    repeat (40) @(negedge clk);
    check("ab_no_req", req_cnt, saved_req);
    check("ab_idle", busy, 0);

    // Scenario 5: measurement never returns
    resp_en = 1'b0;
    launch(1'b0);
    repeat (20) @(negedge clk);
    check("to_err_c20", err, 0);
    check("to_busy_c20", busy, 1);
    @(negedge clk);
    check("to_err_c21", err, 1);
    check_parked("to");
    check("to_done", done, 0);
    launch(1'b0);
    @(negedge clk);
    check("to_err_cleared", err, 0);
    check("to_busy_restart", busy, 1);
    pulse_abort();
    check("to_abort_busy", busy, 0);
    check("to_abort_err", err, 0);
    resp_en = 1'b1;

    // Scenario 6: start held high, spurious meas_done during SETTLE (cycle 6)
    launch(1'b1);
    repeat (5) @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk);
    #1 spur_done = 1'b0;
    wait_done("hs_done", 400);
    check("hs_l", c_l_word, 28);
    check("hs_m", c_m_word, 199);
    check("hs_s", c_s_word, 255);
    check("hs_busy_cycles", busy_cnt, 214);
    check("hs_req_pulses", req_cnt, 21);
    @(negedge clk);
    check("hs_restart_busy", busy, 1);
    check("hs_restart_done", done, 0);
    check("hs_restart_l", c_l_word, 0);

    // Scenario 7: reset in MEAS (cycle 226 of the held run, meas_req at 225)
    repeat (10) @(negedge clk);
    check("rs_l_pre", c_l_word, 16);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_parked("rs");
    check("rs_req", meas_req, 0);
    check("rs_done", done, 0);
    check("rs_err", err, 0);
    saved_req = req_cnt;
    repeat (20) @(negedge clk);
    check("rs_no_req", req_cnt, saved_req);
    check("rs_still_idle", busy, 0);
    check("rs_l_post", c_l_word, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
